// File: rtl/mcu_pkg.sv
// Shared MCU definitions: branch-counter encodings, default widths and the
// saturating 2-bit counter update used by the branch predictor.
package mcu_pkg;

  localparam int DEFAULT_PC_W    = 8;
  localparam int DEFAULT_INSTR_W = 17;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == ST) ? ST : ctr + 2'd1;
    end
    return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/fetch_predict_unit_if.sv
// Fetch-stage bus: program-memory port, IF/ID outputs and the branch
// resolution fed back from EX.
interface fetch_predict_unit_if
  import mcu_pkg::*;
#(
  parameter int PC_W    = DEFAULT_PC_W,
  parameter int INSTR_W = DEFAULT_INSTR_W
);

  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               stall;

  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;
  logic [PC_W-1:0]    if_pc_plus1;
  logic               if_pred_taken;
  logic [PC_W-1:0]    if_pred_target;

  logic               ex_valid;
  logic               ex_is_branch;
  logic [PC_W-1:0]    ex_pc;
  logic               ex_taken;
  logic [PC_W-1:0]    ex_target;
  logic               ex_pred_taken;
  logic [PC_W-1:0]    ex_pred_target;

  logic               flush;

  modport master (
    input  imem_data, stall,
           ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    output imem_addr, if_valid, if_instr, if_pc, if_pc_plus1,
           if_pred_taken, if_pred_target, flush
  );

  modport slave (
    output imem_data, stall,
           ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    input  imem_addr, if_valid, if_instr, if_pc, if_pc_plus1,
           if_pred_taken, if_pred_target, flush
  );

endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit saturating direction counters. Lookup reads
// the registered tables, so a same-cycle update to the same entry is not seen.
module branch_target_buffer
  import mcu_pkg::*;
#(
  parameter int PC_W  = DEFAULT_PC_W,
  parameter int IDX_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            lookup_taken,
  output logic [PC_W-1:0] lookup_target,
  input  logic            train_en,
  input  logic [PC_W-1:0] train_pc,
  input  logic            train_taken,
  input  logic [PC_W-1:0] train_target
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = (PC_W > IDX_W) ? PC_W - IDX_W : 1;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [PC_W-1:0]   target_q [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];

  logic [IDX_W-1:0]  lk_idx;
  logic [IDX_W-1:0]  tr_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic [TAG_W-1:0]  tr_tag;
  logic              hit;

  assign lk_idx = IDX_W'(lookup_pc);
  assign tr_idx = IDX_W'(train_pc);

  // When the index covers the whole PC there is nothing left to tag; a
  // constant zero tag makes the compare always succeed.
  generate
    if (PC_W > IDX_W) begin : g_tag
      assign lk_tag = lookup_pc[PC_W-1:IDX_W];
      assign tr_tag = train_pc[PC_W-1:IDX_W];
    end else begin : g_no_tag
      assign lk_tag = '0;
      assign tr_tag = '0;
    end
  endgenerate

  assign hit           = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lookup_taken  = hit && ctr_q[lk_idx][1];
  assign lookup_target = target_q[lk_idx];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= WNT;
      end
    end else if (train_en) begin
      ctr_q[tr_idx] <= sat_update(ctr_q[tr_idx], train_taken);
      if (train_taken) begin
        valid_q[tr_idx]  <= 1'b1;
        tag_q[tr_idx]    <= tr_tag;
        target_q[tr_idx] <= train_target;
      end
    end
  end

endmodule

// File: rtl/fetch_predict_unit.sv
// Instruction-fetch stage: PC, IF/ID register, BTB-based prediction,
// mispredict redirect/flush and saturating performance counters.
module fetch_predict_unit
  import mcu_pkg::*;
#(
  parameter int              PC_W       = DEFAULT_PC_W,
  parameter int              INSTR_W    = DEFAULT_INSTR_W,
  parameter int              IDX_W      = 4,
  parameter bit              PREDICT_EN = 1'b1,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int              CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_predict_unit_if.master bus,
  output logic [CNT_W-1:0]     branch_cnt,
  output logic [CNT_W-1:0]     mispredict_cnt
);

  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_next;
  logic [PC_W-1:0]    correct_pc;
  logic               res;
  logic               mispred;
  logic               pred;
  logic               lookup_taken;
  logic [PC_W-1:0]    lookup_target;

  logic               if_valid_q;
  logic [INSTR_W-1:0] if_instr_q;
  logic [PC_W-1:0]    if_pc_q;
  logic               if_pred_taken_q;
  logic [PC_W-1:0]    if_pred_target_q;

  branch_target_buffer #(
    .PC_W  (PC_W),
    .IDX_W (IDX_W)
  ) u_btb (
    .clk           (clk),
    .reset         (reset),
    .lookup_pc     (pc),
    .lookup_taken  (lookup_taken),
    .lookup_target (lookup_target),
    .train_en      (res),
    .train_pc      (bus.ex_pc),
    .train_taken   (bus.ex_taken),
    .train_target  (bus.ex_target)
  );

  // A taken branch with the right direction but the wrong target is still a mispredict.
  assign res     = bus.ex_valid & bus.ex_is_branch;
  assign mispred = res & ((bus.ex_taken != bus.ex_pred_taken) |
                          (bus.ex_taken & bus.ex_pred_taken &
                           (bus.ex_target != bus.ex_pred_target)));
  assign correct_pc = bus.ex_taken ? bus.ex_target : bus.ex_pc + PC_W'(1);
  assign pred       = PREDICT_EN & lookup_taken;

  assign bus.flush          = mispred & reset;
  assign bus.imem_addr      = pc;
  assign bus.if_valid       = if_valid_q;
  assign bus.if_instr       = if_instr_q;
  assign bus.if_pc          = if_pc_q;
  assign bus.if_pc_plus1    = if_pc_q + PC_W'(1);
  assign bus.if_pred_taken  = if_pred_taken_q;
  assign bus.if_pred_target = if_pred_target_q;

  always_comb begin
    pc_next = pc + PC_W'(1);
    if (mispred) begin
      pc_next = correct_pc;
    end else if (bus.stall) begin
      pc_next = pc;
    end else if (pred) begin
      pc_next = lookup_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  // The redirect kills the IF/ID slot even under stall; the payload is left stale.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if_valid_q       <= 1'b0;
      if_instr_q       <= '0;
      if_pc_q          <= '0;
      if_pred_taken_q  <= 1'b0;
      if_pred_target_q <= '0;
    end else if (mispred) begin
      if_valid_q <= 1'b0;
    end else if (!bus.stall) begin
      if_valid_q       <= 1'b1;
      if_instr_q       <= bus.imem_data;
      if_pc_q          <= pc;
      if_pred_taken_q  <= pred;
      if_pred_target_q <= pred ? lookup_target : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (res && (branch_cnt != '1)) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end
      if (mispred && (mispredict_cnt != '1)) begin
        mispredict_cnt <= mispredict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_predict_unit.sv
// Directed bench for fetch_predict_unit: one predicting instance (a) and one
// with prediction disabled (b), sharing clock, reset and stall.
module tb_fetch_predict_unit;
  import mcu_pkg::*;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 17;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_predict_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) ifa ();
  fetch_predict_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) ifb ();

  logic [CNT_W-1:0] a_branch_cnt, a_mispredict_cnt;
  logic [CNT_W-1:0] b_branch_cnt, b_mispredict_cnt;

  int compared   = 0;
  int mismatched = 0;

  fetch_predict_unit #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .IDX_W(4), .PREDICT_EN(1'b1),
    .RESET_PC(8'h00), .CNT_W(CNT_W)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(ifa),
    .branch_cnt(a_branch_cnt), .mispredict_cnt(a_mispredict_cnt)
  );

  fetch_predict_unit #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .IDX_W(4), .PREDICT_EN(1'b0),
    .RESET_PC(8'h00), .CNT_W(CNT_W)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(ifb),
    .branch_cnt(b_branch_cnt), .mispredict_cnt(b_mispredict_cnt)
  );

  function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] a);
    return {9'h155, a};
  endfunction

  assign ifa.imem_data = instr_of(ifa.imem_addr);
  assign ifb.imem_data = instr_of(ifb.imem_addr);

  function automatic logic [PC_W-1:0] addr_of(input int sel);
    return (sel == 0) ? ifa.imem_addr : ifb.imem_addr;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic valid, input logic [PC_W-1:0] pc,
                               input logic taken, input logic [PC_W-1:0] target,
                               input logic pred_taken, input logic [PC_W-1:0] pred_target);
    if (sel == 0) begin
      ifa.ex_valid = valid; ifa.ex_is_branch = valid; ifa.ex_pc = pc;
      ifa.ex_taken = taken; ifa.ex_target = target;
      ifa.ex_pred_taken = pred_taken; ifa.ex_pred_target = pred_target;
    end else begin
      ifb.ex_valid = valid; ifb.ex_is_branch = valid; ifb.ex_pc = pc;
      ifb.ex_taken = taken; ifb.ex_target = target;
      ifb.ex_pred_taken = pred_taken; ifb.ex_pred_target = pred_target;
    end
    #1;
  endtask

  task automatic runTo(input int sel, input logic [PC_W-1:0] target, input string tag);
    for (int i = 0; i < 300 && addr_of(sel) != target; i++) tick();
    checkOutput(tag, addr_of(sel), target);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    ifa.stall = 1'b0;
    ifb.stall = 1'b0;
    applyStimulus(0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    applyStimulus(1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    tick();

    checkOutput("rst_imem_addr", ifa.imem_addr, 8'h00);
    checkOutput("rst_if_valid", ifa.if_valid, 1'b0);
    checkOutput("rst_if_instr", ifa.if_instr, 17'h0);
    checkOutput("rst_if_pc", ifa.if_pc, 8'h00);
    checkOutput("rst_if_pred_taken", ifa.if_pred_taken, 1'b0);
    checkOutput("rst_if_pred_target", ifa.if_pred_target, 8'h00);
    checkOutput("rst_branch_cnt", a_branch_cnt, 16'd0);
    checkOutput("rst_mispredict_cnt", a_mispredict_cnt, 16'd0);
    checkOutput("rst_b_if_valid", ifb.if_valid, 1'b0);

    // A mispredict presented while reset is low must neither flush nor redirect.
    applyStimulus(0, 1'b1, 8'h10, 1'b1, 8'h04, 1'b0, 8'h00);
    checkOutput("flush_in_reset", ifa.flush, 1'b0);
    tick();
    checkOutput("reset_discards_redirect", ifa.imem_addr, 8'h00);
    checkOutput("reset_no_count", a_branch_cnt, 16'd0);
    applyStimulus(0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    reset = 1'b1;
    #1;

    tick();
    checkOutput("first_imem_addr", ifa.imem_addr, 8'h01);
    checkOutput("first_if_valid", ifa.if_valid, 1'b1);
    checkOutput("first_if_pc", ifa.if_pc, 8'h00);
    checkOutput("first_if_instr", ifa.if_instr, instr_of(8'h00));
    checkOutput("first_if_pc_plus1", ifa.if_pc_plus1, 8'h01);

    runTo(0, 8'h05, "run_to_5");
    checkOutput("pre_stall_if_pc", ifa.if_pc, 8'h04);
    ifa.stall = 1'b1;
    ifb.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_imem_addr", ifa.imem_addr, 8'h05);
      checkOutput("stall_if_pc", ifa.if_pc, 8'h04);
    end
    checkOutput("stall_if_instr", ifa.if_instr, instr_of(8'h04));
    ifa.stall = 1'b0;
    ifb.stall = 1'b0;
    tick();
    checkOutput("resume_imem_addr", ifa.imem_addr, 8'h06);
    checkOutput("resume_if_pc", ifa.if_pc, 8'h05);
    checkOutput("resume_if_instr", ifa.if_instr, instr_of(8'h05));

    runTo(0, 8'hFF, "run_to_ff");
    tick();
    checkOutput("wrap_imem_addr", ifa.imem_addr, 8'h00);
    checkOutput("wrap_if_pc", ifa.if_pc, 8'hFF);
    checkOutput("wrap_if_pc_plus1", ifa.if_pc_plus1, 8'h00);

    // Train 0x10 -> 0x04 with a not-taken prediction: costs a redirect.
    applyStimulus(0, 1'b1, 8'h10, 1'b1, 8'h04, 1'b0, 8'h00);
    checkOutput("train_flush", ifa.flush, 1'b1);
    tick();
    applyStimulus(0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    checkOutput("train_redirect_addr", ifa.imem_addr, 8'h04);
    checkOutput("train_if_valid", ifa.if_valid, 1'b0);
    checkOutput("train_mispredict_cnt", a_mispredict_cnt, 16'd1);
    checkOutput("train_branch_cnt", a_branch_cnt, 16'd1);
    tick();
    checkOutput("penalty_if_valid", ifa.if_valid, 1'b1);
    checkOutput("penalty_if_pc", ifa.if_pc, 8'h04);
    checkOutput("penalty_if_instr", ifa.if_instr, instr_of(8'h04));

    runTo(0, 8'h10, "run_to_10_a");
    tick();
    checkOutput("pred_if_pred_taken", ifa.if_pred_taken, 1'b1);
    checkOutput("pred_if_pred_target", ifa.if_pred_target, 8'h04);
    checkOutput("pred_if_pc", ifa.if_pc, 8'h10);
    checkOutput("pred_imem_addr", ifa.imem_addr, 8'h04);

    // Correctly predicted taken resolutions saturate the counter at ST.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1'b1, 8'h10, 1'b1, 8'h04, 1'b1, 8'h04);
      checkOutput("sat_taken_no_flush", ifa.flush, 1'b0);
      tick();
    end
    applyStimulus(0, 1'b1, 8'h10, 1'b0, 8'h04, 1'b0, 8'h00);
    checkOutput("nt1_no_flush", ifa.flush, 1'b0);
    tick();
    applyStimulus(0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    checkOutput("nt1_branch_cnt", a_branch_cnt, 16'd6);
    checkOutput("nt1_mispredict_cnt", a_mispredict_cnt, 16'd1);
    runTo(0, 8'h10, "run_to_10_b");
    tick();
    checkOutput("hyst_still_taken", ifa.if_pred_taken, 1'b1);
    checkOutput("hyst_imem_addr", ifa.imem_addr, 8'h04);

    applyStimulus(0, 1'b1, 8'h10, 1'b0, 8'h04, 1'b0, 8'h00);
    tick();
    applyStimulus(0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    runTo(0, 8'h10, "run_to_10_c");
    tick();
    checkOutput("nt2_pred_taken", ifa.if_pred_taken, 1'b0);
    checkOutput("nt2_pred_target", ifa.if_pred_target, 8'h00);
    checkOutput("nt2_imem_addr", ifa.imem_addr, 8'h11);
    checkOutput("nt2_branch_cnt", a_branch_cnt, 16'd7);

    // Redirect wins over stall; IF/ID then stays empty while the stall holds.
    ifa.stall = 1'b1;
    ifb.stall = 1'b1;
    applyStimulus(0, 1'b1, 8'h20, 1'b0, 8'h00, 1'b1, 8'h55);
    checkOutput("simul_flush", ifa.flush, 1'b1);
    tick();
    applyStimulus(0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    checkOutput("simul_imem_addr", ifa.imem_addr, 8'h21);
    checkOutput("simul_if_valid", ifa.if_valid, 1'b0);
    checkOutput("simul_mispredict_cnt", a_mispredict_cnt, 16'd2);
    tick();
    checkOutput("simul_hold_addr", ifa.imem_addr, 8'h21);
    checkOutput("simul_hold_valid", ifa.if_valid, 1'b0);
    ifa.stall = 1'b0;
    ifb.stall = 1'b0;
    tick();
    checkOutput("simul_resume_addr", ifa.imem_addr, 8'h22);
    checkOutput("simul_resume_if_pc", ifa.if_pc, 8'h21);
    checkOutput("simul_resume_valid", ifa.if_valid, 1'b1);

    // Right direction, wrong target.
    applyStimulus(0, 1'b1, 8'h40, 1'b1, 8'h30, 1'b1, 8'h31);
    checkOutput("tgt_flush", ifa.flush, 1'b1);
    tick();
    applyStimulus(0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    checkOutput("tgt_imem_addr", ifa.imem_addr, 8'h30);
    checkOutput("tgt_mispredict_cnt", a_mispredict_cnt, 16'd3);
    checkOutput("tgt_branch_cnt", a_branch_cnt, 16'd9);

    // Prediction disabled: every taken resolution redirects, nothing is predicted.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1'b1, 8'h10, 1'b1, 8'h04, 1'b0, 8'h00);
      checkOutput("nopred_flush", ifb.flush, 1'b1);
      tick();
    end
    applyStimulus(1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    checkOutput("nopred_imem_addr", ifb.imem_addr, 8'h04);
    checkOutput("nopred_branch_cnt", b_branch_cnt, 16'd3);
    checkOutput("nopred_mispredict_cnt", b_mispredict_cnt, 16'd3);
    runTo(1, 8'h10, "run_to_10_b_dut");
    tick();
    checkOutput("nopred_if_pred_taken", ifb.if_pred_taken, 1'b0);
    checkOutput("nopred_if_pred_target", ifb.if_pred_target, 8'h00);
    checkOutput("nopred_next_addr", ifb.imem_addr, 8'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_predict_unit.md
Name: fetch_predict_unit

Overview:
- Parametrised instruction-fetch stage for the pipelined MCU: owns the PC and drives the program-memory address.
- Registers the IF/ID stage and predicts branches with a direct-mapped BTB plus 2-bit saturating counters.
- Takes branch resolution back from EX and redirects/flushes on mispredict.
- Generalises the fixed 8-bit PC and always-not-taken handling to configurable PC/instruction width, table depth and prediction mode.

Parameters:
- PC_W, 8, PC and instruction-memory address width.
- INSTR_W, 17, instruction word width.
- IDX_W, 4, BTB/counter table index bits; table has 2^IDX_W entries indexed by pc[IDX_W-1:0].
- PREDICT_EN, 1, 1 = BTB/counter prediction; 0 = always predict not-taken (tables still train, never consulted).
- RESET_PC, 0, PC value after reset.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- imem_addr  out  PC_W  program-memory address, combinational = pc register.
- imem_data  in  INSTR_W  instruction from program memory (combinational read).
- stall  in  1  hazard stall: hold PC and IF/ID.
- if_valid  out  1  IF/ID holds a live instruction.
- if_instr  out  INSTR_W  IF/ID instruction.
- if_pc  out  PC_W  PC of the IF/ID instruction.
- if_pc_plus1  out  PC_W  if_pc+1 mod 2^PC_W.
- if_pred_taken  out  1  prediction made for if_instr.
- if_pred_target  out  PC_W  predicted target (0 when not taken).
- ex_valid  in  1  EX stage holds a live instruction.
- ex_is_branch  in  1  EX instruction is a branch/jump.
- ex_pc  in  PC_W  PC of the EX instruction.
- ex_taken  in  1  resolved direction.
- ex_target  in  PC_W  resolved target.
- ex_pred_taken  in  1  prediction carried down the pipe.
- ex_pred_target  in  PC_W  predicted target carried down the pipe.
- flush  out  1  combinational: squash the instruction entering EX and the IF/ID slot.
- branch_cnt  out  CNT_W  resolved branches, saturating.
- mispredict_cnt  out  CNT_W  mispredicts, saturating.

Behaviour:
- Reset (reset=0 at a clk edge):
  - pc=RESET_PC; if_valid=0; if_instr=0; if_pc=0; if_pred_taken=0; if_pred_target=0.
  - All counters=2'b01 (weakly not-taken); all BTB valid=0; perf counters=0.
  - flush=0 while reset is low; reset mid-flush discards the redirect.
- Resolution: res = ex_valid & ex_is_branch.
- Mispredict: mispred = res & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_taken & ex_target != ex_pred_target)).
- flush = mispred. Correct next PC = ex_taken ? ex_target : ex_pc+1.
- Lookup (combinational on pc):
  - hit = valid[idx] & tag[idx]==pc[PC_W-1:IDX_W].
  - pred = PREDICT_EN & hit & ctr[idx][1].
- Next PC, in priority order:
  1. mispred -> correct PC.
  2. stall -> hold.
  3. pred -> btb_target[idx].
  4. else pc+1, wrapping 2^PC_W-1 -> 0.
- IF/ID register:
  - mispred: if_valid<=0, other fields don't-care (held). The redirect overrides stall.
  - else if stall: hold all fields.
  - else load imem_data, pc, pred, and pred target (0 if not pred); if_valid<=1.
- Branch penalty: 2 cycles. The correct-path instruction is in IF/ID on the 2nd edge after the mispredict cycle.
- Training, on every res regardless of stall, at ex_pc's index:
  - Counter increments if ex_taken, decrements otherwise, saturating at 3 and 0.
  - If ex_taken: valid<=1, tag<=ex_pc upper bits, target<=ex_target.
  - Not-taken never invalidates the entry.
- Same-cycle lookup and update of the same index: lookup sees the old value (read-before-write).
- Perf counters: branch_cnt+=res, mispredict_cnt+=mispred, both saturating at 2^CNT_W-1.
- Edge case: if IDX_W >= PC_W the tag is zero-width and is ignored.

Decomposition:
- Shared package mcu_pkg:
  - Counter encoding constants: SNT=0, WNT=1, WT=2, ST=3.
  - Default PC_W/INSTR_W.
  - Function sat_update(ctr, taken).
- One sub-module, branch_target_buffer: tables, lookup, training port.
- fetch_predict_unit keeps the PC, IF/ID register, redirect and perf counters.

Test Plan:
- Reset: hold reset=0 for 2 cycles, release with RESET_PC=0, no branches -> imem_addr 0,1,2…; if_valid=1 from the first edge; wrap 255->0 with PC_W=8.
- Stall: assert stall 3 cycles at pc=5 -> imem_addr stays 5; if_pc/if_instr frozen; resumes at 6.
- Training: resolve branch at pc=0x10 taken to 0x04 once (ex_pred_taken=0) -> flush=1, next imem_addr=0x04, mispredict_cnt=1. Next fetch of 0x10 -> if_pred_taken=1, if_pred_target=0x04, next imem_addr=0x04.
- Saturation and hysteresis: 4 taken resolutions at 0x10, then 1 not-taken -> still predicts taken (ctr=2). A second not-taken -> predicts not-taken.
- Simultaneous events: stall=1 with mispred, ex_taken=0, ex_pc=0x20 -> imem_addr=0x21 next cycle; if_valid=0.
- PREDICT_EN=0: train 0x10 taken 3 times -> if_pred_taken always 0; every taken resolution flushes; branch_cnt=3, mispredict_cnt=3.
